div_request_ctrl: RTL and testbench
===================================

# div_request_ctrl

Initiator side of the divider handshake in the IAGC datapath. It takes a measured amplitude sample and a setpoint, and forms the saturated error `reference − sample`. It presents `reference` and `error` as operands to `processor`, drives `start`, waits for the divider's `valid`, then captures and republishes quotient/remainder as one-cycle results. It sits between the sample front end and `processor`, replacing the hand-driven stimulus used today.

## Interface
- `DATA_SIZE`, 14, operand/quotient width (two's complement operands)
- `REMAINDER_SIZE`, 8, remainder width
- `START_CYCLES`, 10, cycles `o_start` is held high per request (≥1)
- `TIMEOUT_CYCLES`, 255, max cycles in WAIT before abort (≥1; used only with `DIV_TIMEOUT_EN`)
- `i_clock`  in  1  single system clock, rising edge
- `i_reset`  in  1  asynchronous, active-high reset
- `i_enable`  in  1  allows new requests to be accepted
- `i_setpoint`  in  DATA_SIZE  signed setpoint, sampled with the sample
- `i_sample`  in  DATA_SIZE  signed measured amplitude
- `i_sample_valid`  in  1  sample strobe
- `o_reference`  out  DATA_SIZE  divider dividend (registered)
- `o_error`  out  DATA_SIZE  divider divisor = sat(setpoint − sample) (registered)
- `o_start`  out  1  divider start
- `i_quotient`  in  DATA_SIZE  divider quotient
- `i_remainder`  in  REMAINDER_SIZE  divider remainder
- `i_valid`  in  1  divider result valid (level; edge-detected here)
- `o_quotient`  out  DATA_SIZE  captured quotient
- `o_remainder`  out  REMAINDER_SIZE  captured remainder
- `o_result_valid`  out  1  one-cycle pulse on new result
- `o_zero_error`  out  1  one-cycle pulse: error was 0, no division issued
- `o_drop`  out  1  one-cycle pulse: sample strobe ignored (busy or disabled)
- `o_busy`  out  1  high in any state but IDLE
- `o_timeout`  out  1  one-cycle pulse on watchdog abort (0 when the watchdog is compiled out)

## Operation
- States: IDLE → LOAD → START → WAIT → DONE → IDLE; WAIT → IDLE on timeout.
- **IDLE**
  - `i_sample_valid & i_enable`: register `o_reference = i_setpoint`, `o_error = sat(i_setpoint − i_sample)`, go to LOAD.
  - `i_sample_valid & !i_enable`: pulse `o_drop`.
- **Error arithmetic:** subtract in DATA_SIZE+1 bits, then clamp.
  - Above `2^(DATA_SIZE−1)−1`: clamp to max positive.
  - Below `−2^(DATA_SIZE−1)`: clamp to min negative.
- **LOAD:** operands are stable for one cycle.
  - Error 0: pulse `o_zero_error`; quotient/remainder outputs hold; return to IDLE.
  - Otherwise: go to START.
- **START:** `o_start = 1` for exactly `START_CYCLES` cycles (down-counter), then WAIT.
- **WAIT:** detect `i_valid` rising edge (prev 0, now 1, prev register cleared at entry to START).
  - On edge: capture `i_quotient`/`i_remainder`, go to DONE.
  - An `i_valid` already high on entry does not count.
- **DONE:** `o_result_valid = 1` for one cycle, then IDLE.
- **Busy strobes:** `i_sample_valid` in any non-IDLE state pulses `o_drop` next cycle; the sample is discarded, with no queueing.
- **`i_enable` low mid-transaction:** the transaction completes normally.
- **Operand stability:** `o_reference`/`o_error` hold from LOAD until the next accepted sample.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Captured quotient/remainder 0.
  - Reset mid-transaction forces `o_start` low and IDLE immediately (asynchronous).
- Strobe at cycle 0 → operands valid at cycle 1 (LOAD) → `o_start` high cycles 2…`START_CYCLES`+1.
- `i_valid` edge sampled at cycle n → `o_quotient` updated and `o_result_valid` high at n+1.
  - Earliest new sample accepted at n+2.
- Edge arriving during START is ignored; `o_start` is never shortened.
- `o_drop` and `o_timeout` are registered: they appear one cycle after the causing condition.

## Configuration
- `DIV_TIMEOUT_EN` defined: watchdog counter runs in WAIT.
  - After `TIMEOUT_CYCLES` cycles without an edge: `o_timeout` pulses one cycle and state returns to IDLE.
  - Captured outputs are not updated.
  - An edge on the final cycle wins over timeout.
- `DIV_TIMEOUT_EN` undefined: no counter, `o_timeout` tied 0, WAIT waits indefinitely.

## Structure
- Shared package `div_req_pkg`:
  - state encoding (IDLE=0, LOAD=1, START=2, WAIT=3, DONE=4, 3 bits)
  - default `START_CYCLES`/`TIMEOUT_CYCLES`
  - counter width `$clog2` helper constant
- One sub-module, `sat_sub`: parameterized saturating signed subtractor (combinational), instantiated once for the error.

## Test plan
- **Normal request:** setpoint 4144, sample 4152 → `o_error` = 14'h3FF8 (−8), `o_start` high 10 cycles. Divider model returns q=14'h0123, r=8'h05 → `o_quotient` 14'h0123, `o_remainder` 8'h05, `o_result_valid` one cycle.
- **Saturation:**
  - setpoint 8191, sample −8192 → `o_error` 14'h1FFF.
  - setpoint −8192, sample 1 → `o_error` 14'h2000.
- **Zero error:** setpoint = sample = 100 → `o_zero_error` one pulse, `o_start` never high, quotient outputs unchanged.
- **Busy and stale valid:**
  - `i_sample_valid` during WAIT → `o_drop` pulse, transaction unaffected.
  - `i_valid` held high from START into WAIT → no capture until it falls and rises again.
- **Timeout (`DIV_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20):** no `i_valid` → `o_timeout` pulse, `o_busy` low, outputs unchanged. Next sample is accepted.
- **Reset mid-START:** assert `i_reset` during START → `o_start` and `o_busy` drop without waiting for a clock. After release, a new sample completes normally.

Source files
------------

// File: rtl/div_req_pkg.sv
// Shared definitions for the divider request controller: state encoding,
// default timing parameters and the shared-counter width helper.
package div_req_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_START_CYCLES   = 10;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // The counter is loaded with (cycles - 1), so it must hold max(cycles) - 1.
    function automatic int cnt_width(input int start_cycles, input int timeout_cycles);
        int m;
        m = (start_cycles > timeout_cycles) ? start_cycles : timeout_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_START_CYCLES, DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/sat_sub.sv
// Saturating signed subtractor: y = clamp(a - b) to the W-bit two's complement range.
module sat_sub #(
    parameter int W = 14
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    localparam logic signed [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W:0] diff;

    always_comb begin
        diff = {a[W-1], a} - {b[W-1], b};
        // The top two bits disagree only when the true result left the W-bit range.
        if (diff[W] != diff[W-1]) begin
            y = diff[W] ? MIN_NEG : MAX_POS;
        end else begin
            y = diff[W-1:0];
        end
    end

endmodule

// File: rtl/div_request_ctrl.sv
// Divider handshake initiator: forms sat(setpoint - sample), drives start,
// captures the result on a valid rising edge. Optional watchdog: DIV_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an enabled sample strobe
// LOAD  | operands registered, zero-error check
// START | o_start held high for START_CYCLES cycles
// WAIT  | waiting for a fresh i_valid rising edge (watchdog if enabled)
// DONE  | o_result_valid pulse cycle
module div_request_ctrl
    import div_req_pkg::*;
#(
    parameter int DATA_SIZE      = 14,
    parameter int REMAINDER_SIZE = 8,
    parameter int START_CYCLES   = DEF_START_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [DATA_SIZE-1:0]      i_setpoint,
    input  logic [DATA_SIZE-1:0]      i_sample,
    input  logic                      i_sample_valid,
    output logic [DATA_SIZE-1:0]      o_reference,
    output logic [DATA_SIZE-1:0]      o_error,
    output logic                      o_start,
    input  logic [DATA_SIZE-1:0]      i_quotient,
    input  logic [REMAINDER_SIZE-1:0] i_remainder,
    input  logic                      i_valid,
    output logic [DATA_SIZE-1:0]      o_quotient,
    output logic [REMAINDER_SIZE-1:0] o_remainder,
    output logic                      o_result_valid,
    output logic                      o_zero_error,
    output logic                      o_drop,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int CNT_W = cnt_width(START_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 valid_prev;
    logic [DATA_SIZE-1:0] error_next;
    logic                 valid_edge;

`ifdef DIV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_q;
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    sat_sub #(.W(DATA_SIZE)) u_err_sub (
        .a (i_setpoint),
        .b (i_sample),
        .y (error_next)
    );

    assign valid_edge = i_valid & ~valid_prev;
    assign o_busy     = (state != ST_IDLE);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            valid_prev     <= 1'b0;
            o_reference    <= '0;
            o_error        <= '0;
            o_start        <= 1'b0;
            o_quotient     <= '0;
            o_remainder    <= '0;
            o_result_valid <= 1'b0;
            o_zero_error   <= 1'b0;
            o_drop         <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
        end else begin
            o_drop         <= i_sample_valid & ((state != ST_IDLE) | ~i_enable);
            o_zero_error   <= 1'b0;
            o_result_valid <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (i_sample_valid && i_enable) begin
                        o_reference <= i_setpoint;
                        o_error     <= error_next;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (o_error == '0) begin
                        o_zero_error <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        o_start    <= 1'b1;
                        cnt        <= START_LOAD;
                        valid_prev <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    // Tracking i_valid here makes an edge during START (or a level
                    // already high on entry to WAIT) look stale to the WAIT detector.
                    valid_prev <= i_valid;
                    if (cnt == '0) begin
                        o_start <= 1'b0;
                        state   <= ST_WAIT;
`ifdef DIV_TIMEOUT_EN
                        cnt     <= TIMEOUT_LOAD;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    valid_prev <= i_valid;
                    if (valid_edge) begin
                        o_quotient     <= i_quotient;
                        o_remainder    <= i_remainder;
                        o_result_valid <= 1'b1;
                        state          <= ST_DONE;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (cnt == '0) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_request_ctrl.sv
// Self-checking bench for div_request_ctrl: directed cases plus randomized
// transactions checked against a cycle-timeline model of the handshake.
`timescale 1ns/1ps
module tb_div_request_ctrl;

    localparam int DW = 14;
    localparam int RW = 8;
    localparam int SC = 10;
    localparam int TC = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_enable;
    logic [DW-1:0] i_setpoint;
    logic [DW-1:0] i_sample;
    logic          i_sample_valid;
    logic [DW-1:0] o_reference;
    logic [DW-1:0] o_error;
    logic          o_start;
    logic [DW-1:0] i_quotient;
    logic [RW-1:0] i_remainder;
    logic          i_valid;
    logic [DW-1:0] o_quotient;
    logic [RW-1:0] o_remainder;
    logic          o_result_valid;
    logic          o_zero_error;
    logic          o_drop;
    logic          o_busy;
    logic          o_timeout;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] last_q;
    logic [RW-1:0] last_r;

    always #5 clk = ~clk;

    div_request_ctrl #(
        .DATA_SIZE(DW), .REMAINDER_SIZE(RW), .START_CYCLES(SC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(i_enable),
        .i_setpoint(i_setpoint), .i_sample(i_sample), .i_sample_valid(i_sample_valid),
        .o_reference(o_reference), .o_error(o_error), .o_start(o_start),
        .i_quotient(i_quotient), .i_remainder(i_remainder), .i_valid(i_valid),
        .o_quotient(o_quotient), .o_remainder(o_remainder),
        .o_result_valid(o_result_valid), .o_zero_error(o_zero_error),
        .o_drop(o_drop), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_err(input int sp, input int smp);
        int d;
        d = sp - smp;
        if (d > (1 << (DW-1)) - 1) d = (1 << (DW-1)) - 1;
        if (d < -(1 << (DW-1)))    d = -(1 << (DW-1));
        return d[DW-1:0];
    endfunction

    // Issue a strobe and count how many cycles o_start stays high.
    task automatic request_and_start(input int sp, input int smp, input bit stale, output int n);
        i_setpoint     = sp[DW-1:0];
        i_sample       = smp[DW-1:0];
        i_sample_valid = 1'b1;
        @(negedge clk);
        i_sample_valid = 1'b0;
        i_setpoint     = DW'($urandom);
        i_sample       = DW'($urandom);
        @(negedge clk);
        n = 0;
        while (o_start && n < 4*SC) begin
            n++;
            if (stale && n == SC-2) i_valid = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input int sp, input int smp, input logic [DW-1:0] q, input logic [RW-1:0] r,
                           input int lat, input bit stale, input bit busy_strobe, input bit en_drop);
        logic [DW-1:0] e;
        int n;
        int pulses;
        e = model_err(sp, smp);
        i_quotient  = ~q;
        i_remainder = ~r;
        i_setpoint     = sp[DW-1:0];
        i_sample       = smp[DW-1:0];
        i_sample_valid = 1'b1;
        @(negedge clk);
        i_sample_valid = 1'b0;
        if (en_drop) i_enable = 1'b0;
        check("load_ref", o_reference, sp[DW-1:0]);
        check("load_err", o_error, e);
        check("load_busy", o_busy, 1);
        check("load_nostart", o_start, 0);
        if (e == '0) begin
            @(negedge clk);
            check("zero_pulse", o_zero_error, 1);
            check("zero_idle", o_busy, 0);
            check("zero_nostart", o_start, 0);
            check("zero_q_hold", o_quotient, last_q);
            check("zero_r_hold", o_remainder, last_r);
            @(negedge clk);
            check("zero_once", o_zero_error, 0);
            i_enable = 1'b1;
            return;
        end
        @(negedge clk);
        n = 0;
        while (o_start && n < 4*SC) begin
            n++;
            if (stale && n == SC-2) i_valid = 1'b1;
            @(negedge clk);
        end
        check("start_len", n, SC);
        if (busy_strobe) begin
            i_sample_valid = 1'b1;
            i_setpoint     = DW'($urandom);
            i_sample       = DW'($urandom);
            @(negedge clk);
            i_sample_valid = 1'b0;
            check("busy_drop", o_drop, 1);
            check("busy_ref_hold", o_reference, sp[DW-1:0]);
            check("busy_err_hold", o_error, e);
        end
        if (stale) begin
            pulses = 0;
            repeat (3) begin
                @(negedge clk);
                if (o_result_valid) pulses++;
            end
            check("stale_no_capture", pulses, 0);
            check("stale_busy", o_busy, 1);
            i_valid = 1'b0;
            @(negedge clk);
        end
        repeat (lat) @(negedge clk);
        check("pre_edge_busy", o_busy, 1);
        i_quotient  = q;
        i_remainder = r;
        i_valid     = 1'b1;
        @(negedge clk);
        i_quotient  = ~q;
        i_remainder = ~r;
        check("res_valid", o_result_valid, 1);
        check("res_q", o_quotient, q);
        check("res_r", o_remainder, r);
        check("res_busy", o_busy, 1);
        last_q = q;
        last_r = r;
        i_valid = 1'(($urandom & 1));
        @(negedge clk);
        i_valid = 1'b0;
        check("res_once", o_result_valid, 0);
        check("res_idle", o_busy, 0);
        check("res_q_hold", o_quotient, q);
        i_enable = 1'b1;
    endtask

    task automatic watchdog_test();
        int n;
        request_and_start(500, 321, 1'b0, n);
        check("wd_start_len", n, SC);
`ifdef DIV_TIMEOUT_EN
        n = 0;
        while (!o_timeout && n < 5*TC) begin
            @(negedge clk);
            n++;
        end
        check("wd_cycles", n, TC);
        check("wd_idle", o_busy, 0);
        check("wd_no_result", o_result_valid, 0);
        check("wd_q_hold", o_quotient, last_q);
        check("wd_r_hold", o_remainder, last_r);
        @(negedge clk);
        check("wd_once", o_timeout, 0);
`else
        repeat (300) @(negedge clk);
        check("nowd_busy", o_busy, 1);
        check("nowd_timeout", o_timeout, 0);
        i_quotient  = 14'h0ABC;
        i_remainder = 8'h3C;
        i_valid     = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        check("nowd_res_valid", o_result_valid, 1);
        check("nowd_res_q", o_quotient, 14'h0ABC);
        last_q = 14'h0ABC;
        last_r = 8'h3C;
        @(negedge clk);
        check("nowd_idle", o_busy, 0);
`endif
    endtask

    task automatic reset_mid_start();
        int n;
        i_setpoint     = 14'd300;
        i_sample       = 14'd20;
        i_sample_valid = 1'b1;
        @(negedge clk);
        i_sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pre_start", o_start, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_start", o_start, 0);
        check("rst_async_busy", o_busy, 0);
        check("rst_q_cleared", o_quotient, 0);
        @(negedge clk);
        rst = 1'b0;
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        n = 0;
        check("rst_post_idle", o_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int sp;
        int smp;
        i_enable = 1'b1;
        i_setpoint = '0;
        i_sample = '0;
        i_sample_valid = 1'b0;
        i_quotient = '0;
        i_remainder = '0;
        i_valid = 1'b0;
        last_q = '0;
        last_r = '0;
        repeat (2) @(negedge clk);
        check("rst_start", o_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_q", o_quotient, 0);
        check("rst_r", o_remainder, 0);
        check("rst_ref", o_reference, 0);
        check("rst_err", o_error, 0);
        check("rst_outs", {o_result_valid, o_zero_error, o_drop, o_timeout}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(4144, 4152, 14'h0123, 8'h05, 2, 1'b0, 1'b0, 1'b0);
        run_txn(8191, -8192, 14'h0042, 8'h11, 0, 1'b0, 1'b0, 1'b0);
        run_txn(-8192, 1, 14'h1F00, 8'hA5, 3, 1'b0, 1'b0, 1'b0);
        run_txn(100, 100, 14'h3333, 8'h77, 0, 1'b0, 1'b0, 1'b0);
        run_txn(-50, 700, 14'h2222, 8'h99, 1, 1'b1, 1'b1, 1'b1);

        i_enable       = 1'b0;
        i_sample_valid = 1'b1;
        @(negedge clk);
        i_sample_valid = 1'b0;
        i_enable       = 1'b1;
        check("dis_drop", o_drop, 1);
        check("dis_busy", o_busy, 0);
        @(negedge clk);
        check("dis_drop_once", o_drop, 0);

        watchdog_test();
        run_txn(-1000, 2000, 14'h0777, 8'h0E, 1, 1'b0, 1'b0, 1'b0);

        reset_mid_start();
        run_txn(1234, -4321, 14'h1234, 8'h56, 2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: begin sp = 8191 - int'($urandom_range(0, 3)); smp = -8192 + int'($urandom_range(0, 3)); end
                1: begin sp = -8192 + int'($urandom_range(0, 3)); smp = 8191 - int'($urandom_range(0, 3)); end
                2: begin sp = int'($urandom_range(0, 16383)) - 8192; smp = sp; end
                default: begin
                    sp  = int'($urandom_range(0, 16383)) - 8192;
                    smp = int'($urandom_range(0, 16383)) - 8192;
                end
            endcase
            run_txn(sp, smp, DW'($urandom), RW'($urandom), int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
